// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Accepts one ALU command at a time and presents it to an external
// registered ALU. The command goes through these steps:
//   IDLE    -> waits for a command (cmd_ready high)
//   ISSUE   -> holds one-hot select and operands for ISSUE_CYCLES cycles
//   CAPTURE -> operands and selects are back at zero; samples alu_out
//   RESP    -> holds the response until the consumer takes it
// A divide by zero is never sent to the ALU. It goes straight from IDLE to
// RESP with rsp_data = 8'hFF and rsp_err = 1.
// Every output comes directly from a flop.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  sequencer is idle and can accept a command
//   cmd_op     in   2'b00 mul, 2'b01 add, 2'b10 div, 2'b11 sub
//   cmd_a      in   operand a (unsigned, 4 bits)
//   cmd_b      in   operand b (unsigned, 4 bits)
//   a, b       out  isolated operands to the ALU (zero outside ISSUE)
//   sel1..4    out  one-hot ALU select: mul, add, div, sub
//   alu_out    in   registered ALU result
//   rsp_valid  out  response available
//   rsp_ready  in   consumer accepts the response
//   rsp_data   out  result, alu_out passed through unmodified
//   rsp_err    out  divide-by-zero flag
//   busy       out  high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int ISSUE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b10;

  // The counter only has to reach ISSUE_CYCLES-1.
  localparam int CNT_W = (ISSUE_CYCLES > 2) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;      // {sub, div, add, mul}
  logic [3:0]       a_d, b_d;
  logic             rsp_valid_d, rsp_err_d;
  logic [7:0]       rsp_data_d;
  logic             cmd_ready_d, busy_d;

  assign sel1 = sel_q[0];
  assign sel2 = sel_q[1];
  assign sel3 = sel_q[2];
  assign sel4 = sel_q[3];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without
    // these defaults, a branch that skips a signal would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    a_d         = a;
    b_d         = b;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == OP_DIV && cmd_b == 4'd0) begin
            // Divide by zero skips the ALU. Selects and operands stay at zero.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            cnt_d   = '0;
            sel_d   = 4'b0001 << cmd_op;
            a_d     = cmd_a;
            b_d     = cmd_b;
          end
        end
      end

      S_ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          // The ALU samples the held select on this same edge, so the select
          // can be dropped here without losing the result.
          state_d = S_CAPTURE;
          cnt_d   = '0;
          sel_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_err_d   = 1'b0;
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake flags come from flops. Compute them from the next state so
    // they stay aligned with state_q.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled only on the clock edge, so asserting rst has no
  // effect until the next rising clk.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all state. That way every flop
    // samples the pre-edge values together, whatever the statement order.
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      a         <= '0;
      b         <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      a         <= a_d;
      b         <= b_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed and random stimulus for alu_op_sequencer with ISSUE_CYCLES = 2.
// The bench includes a small registered ALU model that responds to the
// select lines. Expected results are computed from the command fields.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int ISSUE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel1, sel2, sel3, sel4;
  logic [7:0] alu_out = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_sequencer #(.ISSUE_CYCLES(ISSUE_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .a         (a),
    .b         (b),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .sel4      (sel4),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Registered ALU: updates only while a select is high and holds otherwise.
  always @(posedge clk) begin
    if (sel1)      alu_out <= {4'd0, a} * {4'd0, b};
    else if (sel2) alu_out <= {4'd0, a} + {4'd0, b};
    else if (sel3) alu_out <= (b == 4'd0) ? 8'hEE : ({4'd0, a} / {4'd0, b});
    else if (sel4) alu_out <= {4'd0, a} - {4'd0, b};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sel_vec();
    return {sel4, sel3, sel2, sel1};
  endfunction

  // Runs one command through the sequencer and checks it cycle by cycle.
  // hold_rsp is the number of extra cycles rsp_ready stays low in RESP.
  // With keep_valid set, cmd_valid stays high (with a different command)
  // until the response is released.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] ca, input logic [3:0] cb,
                        input int hold_rsp, input bit keep_valid, input string tag);
    logic [7:0] exp_data;
    logic       exp_err;
    logic [3:0] exp_sel;
    bit         div0;
    div0 = (op == 2'b10) && (cb == 4'd0);
    case (op)
      2'b00:   exp_data = {4'd0, ca} * {4'd0, cb};
      2'b01:   exp_data = {4'd0, ca} + {4'd0, cb};
      2'b10:   exp_data = div0 ? 8'hFF : ({4'd0, ca} / {4'd0, cb});
      default: exp_data = {4'd0, ca} - {4'd0, cb};
    endcase
    exp_err = div0;
    exp_sel = 4'b0001 << op;

    check({tag, "/ready_before"}, 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = ca;
    cmd_b     = cb;
    step();  // accept edge
    if (keep_valid) begin
      cmd_op = ~op;
      cmd_a  = ~ca;
      cmd_b  = ca ^ cb ^ 4'd5;
    end else begin
      cmd_valid = 1'b0;
    end

    if (!div0) begin
      for (int i = 0; i < ISSUE_CYCLES; i++) begin
        check({tag, "/issue_sel"}, 16'(sel_vec()), 16'(exp_sel));
        check({tag, "/issue_a"}, 16'(a), 16'(ca));
        check({tag, "/issue_b"}, 16'(b), 16'(cb));
        check({tag, "/issue_ready"}, 16'(cmd_ready), 16'd0);
        check({tag, "/issue_busy"}, 16'(busy), 16'd1);
        check({tag, "/issue_rspv"}, 16'(rsp_valid), 16'd0);
        step();
      end
      check({tag, "/cap_sel"}, 16'(sel_vec()), 16'd0);
      check({tag, "/cap_ab"}, 16'({a, b}), 16'd0);
      check({tag, "/cap_rspv"}, 16'(rsp_valid), 16'd0);
      step();
    end

    // Now in RESP.
    check({tag, "/rsp_valid"}, 16'(rsp_valid), 16'd1);
    check({tag, "/rsp_data"}, 16'(rsp_data), 16'(exp_data));
    check({tag, "/rsp_err"}, 16'(rsp_err), 16'(exp_err));
    check({tag, "/rsp_sel"}, 16'(sel_vec()), 16'd0);
    check({tag, "/rsp_ab"}, 16'({a, b}), 16'd0);
    check({tag, "/rsp_ready_out"}, 16'(cmd_ready), 16'd0);
    for (int i = 0; i < hold_rsp; i++) begin
      step();
      check({tag, "/hold_valid"}, 16'(rsp_valid), 16'd1);
      check({tag, "/hold_data"}, 16'(rsp_data), 16'(exp_data));
      check({tag, "/hold_err"}, 16'(rsp_err), 16'(exp_err));
      check({tag, "/hold_cmd_ready"}, 16'(cmd_ready), 16'd0);
      check({tag, "/hold_sel"}, 16'(sel_vec()), 16'd0);
    end
    rsp_ready = 1'b1;
    step();  // release edge
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check({tag, "/done_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "/done_ready"}, 16'(cmd_ready), 16'd1);
    check({tag, "/done_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    rsp_ready = 1'b0;

    // Reset state.
    step();
    step();
    check("reset/cmd_ready", 16'(cmd_ready), 16'd1);
    check("reset/busy", 16'(busy), 16'd0);
    check("reset/rsp_valid", 16'(rsp_valid), 16'd0);
    check("reset/rsp_data", 16'(rsp_data), 16'd0);
    check("reset/rsp_err", 16'(rsp_err), 16'd0);
    check("reset/ab", 16'({a, b}), 16'd0);
    check("reset/sel", 16'(sel_vec()), 16'd0);
    rst = 1'b1;
    step();

    // mul 7*9 = 63, response three edges after accept.
    do_cmd(2'b00, 4'd7, 4'd9, 0, 1'b0, "mul");

    // add 5+6 = 11.
    do_cmd(2'b01, 4'd5, 4'd6, 1, 1'b0, "add");

    // div 9/3 = 3.
    do_cmd(2'b10, 4'd9, 4'd3, 0, 1'b0, "div");

    // Divide by zero: no select, FF with error flag one cycle after accept.
    do_cmd(2'b10, 4'd5, 4'd0, 2, 1'b0, "div0");

    // Back-pressure: sub 3-1 = 2 held for 5 cycles with rsp_ready low.
    do_cmd(2'b11, 4'd3, 4'd1, 5, 1'b0, "backpressure");
    step();
    check("backpressure/idle_after", 16'(cmd_ready), 16'd1);

    // cmd_valid held high while busy: only the first command executes.
    do_cmd(2'b00, 4'd15, 4'd15, 1, 1'b1, "keep_valid");
    step();
    check("keep_valid/no_second_cmd", 16'(busy), 16'd0);
    check("keep_valid/no_second_sel", 16'(sel_vec()), 16'd0);

    // rsp_ready pulsed in IDLE is ignored.
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle_rsp_ready/cmd_ready", 16'(cmd_ready), 16'd1);
    check("idle_rsp_ready/busy", 16'(busy), 16'd0);
    check("idle_rsp_ready/rsp_valid", 16'(rsp_valid), 16'd0);

    // Reset during the second ISSUE cycle of an add.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 4'd4;
    cmd_b     = 4'd2;
    step();  // accept
    cmd_valid = 1'b0;
    check("midreset/issue1_sel", 16'(sel_vec()), 16'b0010);
    step();  // second ISSUE cycle
    check("midreset/issue2_sel", 16'(sel_vec()), 16'b0010);
    rst = 1'b0;
    #2;
    check("midreset/no_async_sel", 16'(sel_vec()), 16'b0010);
    check("midreset/no_async_ready", 16'(cmd_ready), 16'd0);
    step();  // reset edge
    rst = 1'b1;
    check("midreset/sel", 16'(sel_vec()), 16'd0);
    check("midreset/ab", 16'({a, b}), 16'd0);
    check("midreset/rsp_valid", 16'(rsp_valid), 16'd0);
    check("midreset/cmd_ready", 16'(cmd_ready), 16'd1);
    check("midreset/busy", 16'(busy), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midreset/no_response", 16'(rsp_valid), 16'd0);
      check("midreset/stays_idle", 16'(cmd_ready), 16'd1);
    end

    // Random 200-command run. Isolation and one-hot selects are checked on
    // every cycle inside do_cmd.
    for (int n = 0; n < 200; n++) begin
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
